// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge's APB master port and apb_slave_mem.
// Clock and reset are kept as plain ports on the modules, not carried here.
interface apb_slave_mem_if;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with programmable wait states.
// Define APB_SLV_PROT_CHK_EN to add the sticky prot_err protocol checker output.
module apb_slave_mem #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH       = 16,
   parameter int          WAIT_STATES = 0
) (
   input  logic          clock,
   input  logic          presetn,
   apb_slave_mem_if.slave bus
`ifdef APB_SLV_PROT_CHK_EN
   ,
   output logic          prot_err
`endif
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic          lat_write;
   logic [31:0]   lat_wdata;
   logic          lat_valid;
   logic [AW-1:0] lat_idx;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   offset;
   logic          dec_valid;
   logic [AW-1:0] dec_idx;

   // Offset wraps in 32 bits, so addresses below BASE_ADDR land far out of range.
   always_comb begin
      offset    = bus.paddr - BASE_ADDR;
      dec_valid = (offset < SPAN) && (bus.paddr[1:0] == 2'b00);
      dec_idx   = offset[AW+1:2];
   end

   // NOTE: the memory is built from flops and must reset to zero, so it shares
   // the async reset branch with the FSM instead of being a resetless RAM array.
   always_ff @(posedge clock or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         lat_valid <= 1'b0;
         lat_idx   <= '0;
         bus.prdata  <= '0;
         bus.pready  <= 1'b0;
         bus.pslverr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // NOTE: non-blocking throughout; pready/pslverr default low so they
         // pulse for exactly the completing cycle.
         bus.pready  <= 1'b0;
         bus.pslverr <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.psel && !bus.penable) begin
                  state     <= SETUP;
                  lat_write <= bus.pwrite;
                  lat_wdata <= bus.pwdata;
                  lat_valid <= dec_valid;
                  lat_idx   <= dec_idx;
               end
            end
            SETUP: begin
               if (bus.psel && bus.penable) begin
                  state    <= ACCESS;
                  wait_cnt <= 4'(WAIT_STATES);
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (!bus.psel) begin
                  state <= IDLE;
               end else if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  state      <= IDLE;
                  bus.pready <= 1'b1;
                  if (lat_valid) begin
                     if (lat_write) mem[lat_idx] <= lat_wdata;
                     else           bus.prdata   <= mem[lat_idx];
                  end else begin
                     bus.pslverr <= 1'b1;
                     if (!lat_write) bus.prdata <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef APB_SLV_PROT_CHK_EN
   logic [31:0] lat_addr;

   // Master must hold the transfer stable from SETUP until pready.
   always_ff @(posedge clock or negedge presetn) begin
      if (!presetn) begin
         lat_addr <= '0;
         prot_err <= 1'b0;
      end else begin
         if (state == IDLE && bus.psel && !bus.penable) lat_addr <= bus.paddr;
         if (state == ACCESS) begin
            if (!bus.psel || bus.paddr != lat_addr || bus.pwrite != lat_write ||
                bus.pwdata != lat_wdata)
               prot_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: two apb_slave_mem instances (0 and 3 wait states) against an array model.
`timescale 1ns/1ps
module tb_apb_slave_mem;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic clock = 1'b0;
   logic presetn;
   logic [31:0] paddr, pwdata;
   logic pwrite, penable, psel0, psel1;
   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [2][DEPTH];
   logic [31:0] last_rd [2];

   always #5 clock = ~clock;

   apb_slave_mem_if bus0 ();
   apb_slave_mem_if bus1 ();
   assign bus0.paddr = paddr;  assign bus1.paddr = paddr;
   assign bus0.pwdata = pwdata; assign bus1.pwdata = pwdata;
   assign bus0.pwrite = pwrite; assign bus1.pwrite = pwrite;
   assign bus0.penable = penable; assign bus1.penable = penable;
   assign bus0.psel = psel0;    assign bus1.psel = psel1;

`ifdef APB_SLV_PROT_CHK_EN
   logic prot0, prot1;
   apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0))
      dut0 (.clock(clock), .presetn(presetn), .bus(bus0), .prot_err(prot0));
   apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3))
      dut1 (.clock(clock), .presetn(presetn), .bus(bus1), .prot_err(prot1));
`else
   apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0))
      dut0 (.clock(clock), .presetn(presetn), .bus(bus0));
   apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3))
      dut1 (.clock(clock), .presetn(presetn), .bus(bus1));
`endif

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic pready_of(input int d);
      return (d == 0) ? bus0.pready : bus1.pready;
   endfunction

   function automatic logic pslverr_of(input int d);
      return (d == 0) ? bus0.pslverr : bus1.pslverr;
   endfunction

   function automatic logic [31:0] prdata_of(input int d);
      return (d == 0) ? bus0.prdata : bus1.prdata;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = '0;
         for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
      end
   endtask

   task automatic go_idle();
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      @(negedge clock);
      check("pready0 one-cycle", 32'(bus0.pready), 32'd0);
      check("pready1 one-cycle", 32'(bus1.pready), 32'd0);
   endtask

   // Full transfer from setup phase to the negedge where pready is seen; leaves bus in access phase.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input string tag);
      logic [31:0] off;
      logic        valid;
      int          cyc;
      off   = addr - BASE;
      valid = (off < 32'(DEPTH * 4)) && (addr[1:0] == 2'b00);
      paddr = addr; pwrite = wr; pwdata = wd; penable = 1'b0;
      psel0 = (d == 0); psel1 = (d == 1);
      @(negedge clock);
      penable = 1'b1;
      check({tag, " pready low in setup"}, 32'(pready_of(d)), 32'd0);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!pready_of(d) && cyc < 40);
      check({tag, " latency"}, 32'(cyc), 32'(ws_of(d) + 2));
      check({tag, " pslverr"}, 32'(pslverr_of(d)), 32'(!valid));
      if (wr) begin
         if (valid) mdl[d][off >> 2] = wd;
      end else begin
         last_rd[d] = valid ? mdl[d][off >> 2] : 32'h0;
      end
      check({tag, " prdata"}, prdata_of(d), last_rd[d]);
   endtask

   initial begin
      logic [31:0] a, w;
      int d, r;
      presetn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      pwrite = 1'b0; paddr = '0; pwdata = '0;
      clear_model();
      repeat (3) @(negedge clock);
      check("reset prdata0", bus0.prdata, 32'h0);
      check("reset pready1", 32'(bus1.pready), 32'd0);
      check("reset pslverr0", 32'(bus0.pslverr), 32'd0);
`ifdef APB_SLV_PROT_CHK_EN
      check("reset prot_err", 32'(prot1), 32'd0);
`endif
      presetn = 1'b1;
      @(negedge clock);
      xfer(0, 1'b0, BASE, 32'h0, "rst rd0"); go_idle();
      xfer(1, 1'b0, BASE, 32'h0, "rst rd1"); go_idle();

      // Zero-wait write/read, then back-to-back with no idle cycle.
      xfer(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, "ws0 wr"); go_idle();
      xfer(0, 1'b0, BASE + 32'h4, 32'h0, "ws0 rd");
      check("ws0 rd value", bus0.prdata, 32'hDEAD_BEEF);
      go_idle();
      xfer(0, 1'b1, BASE + 32'h8, 32'h0BAD_F00D, "b2b wr");
      xfer(0, 1'b0, BASE + 32'h8, 32'h0, "b2b rd");
      xfer(0, 1'b0, BASE + 32'h4, 32'h0, "b2b rd2"); go_idle();

      // Three wait states on the top word.
      xfer(1, 1'b1, BASE + 32'h3C, 32'h1234_5678, "ws3 wr"); go_idle();
      xfer(1, 1'b0, BASE + 32'h3C, 32'h0, "ws3 rd"); go_idle();

      // Error responses leave memory intact.
      xfer(0, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, "oor wr"); go_idle();
      xfer(0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, "misal wr"); go_idle();
      for (int i = 0; i < DEPTH; i++) xfer(0, 1'b0, BASE + 32'(i * 4), 32'h0, "scan rd");
      go_idle();

      // psel dropped in ACCESS: no write, no response.
      paddr = BASE + 32'h10; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; psel0 = 1'b1; penable = 1'b0;
      @(negedge clock); penable = 1'b1;
      @(negedge clock); psel0 = 1'b0; penable = 1'b0;
      @(negedge clock); check("abort pready", 32'(bus0.pready), 32'd0);
      @(negedge clock); check("abort pready late", 32'(bus0.pready), 32'd0);
      xfer(0, 1'b0, BASE + 32'h10, 32'h0, "abort rd"); go_idle();

      // Randomised traffic over both instances.
      for (int n = 0; n < 60; n++) begin
         d = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 19));
         if (r < 16)       a = BASE + 32'(r * 4);
         else if (r == 16) a = BASE + 32'h40;
         else if (r == 17) a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
         else if (r == 18) a = BASE - 32'h4;
         else              a = $urandom;
         w = $urandom;
         xfer(d, 1'($urandom_range(0, 1)), a, w, "rand");
         if ($urandom_range(0, 1) == 0) go_idle();
      end
      go_idle();

      // Reset during a wait state clears outputs at once and wipes memory.
      xfer(1, 1'b1, BASE + 32'h3C, 32'hCAFE_0001, "pre-rst wr"); go_idle();
      xfer(1, 1'b0, BASE + 32'h3C, 32'h0, "pre-rst rd"); go_idle();
      paddr = BASE + 32'h3C; pwrite = 1'b0; psel1 = 1'b1; penable = 1'b0;
      @(negedge clock); penable = 1'b1;
      @(negedge clock);
      @(negedge clock);
      presetn = 1'b0;
      #1;
      check("midrst prdata", bus1.prdata, 32'h0);
      check("midrst pready", 32'(bus1.pready), 32'd0);
      check("midrst pslverr", 32'(bus1.pslverr), 32'd0);
      clear_model();
      psel1 = 1'b0; penable = 1'b0;
      @(negedge clock);
`ifdef APB_SLV_PROT_CHK_EN
      check("midrst prot_err", 32'(prot0), 32'd0);
`endif
      presetn = 1'b1;
      @(negedge clock);
      for (int i = 0; i < DEPTH; i++) xfer(1, 1'b0, BASE + 32'(i * 4), 32'h0, "post-rst rd");
      xfer(0, 1'b0, BASE + 32'h4, 32'h0, "post-rst rd0"); go_idle();

`ifdef APB_SLV_PROT_CHK_EN
      // Address changes during wait states: flag sticks, write uses latched address.
      paddr = BASE + 32'h20; pwrite = 1'b1; pwdata = 32'h5555_AAAA; psel1 = 1'b1; penable = 1'b0;
      @(negedge clock); penable = 1'b1;
      @(negedge clock); paddr = BASE + 32'h24;
      r = 0;
      do begin @(negedge clock); r++; end while (!bus1.pready && r < 40);
      check("prot latency", 32'(r), 32'd4);
      check("prot_err set", 32'(prot1), 32'd1);
      mdl[1][8] = 32'h5555_AAAA;
      go_idle();
      check("prot_err sticky", 32'(prot1), 32'd1);
      xfer(1, 1'b0, BASE + 32'h20, 32'h0, "prot rd latched");
      xfer(1, 1'b0, BASE + 32'h24, 32'h0, "prot rd other"); go_idle();
      check("prot_err still", 32'(prot1), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
